// File: rtl/conv2d_pkg.sv
// Shared types and defaults for the conv2d result path.
// Holds the tx state encoding and default widths.
package conv2d_pkg;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LOADED,
    S_STREAM,
    S_DONE
  } tx_state_t;

endpackage

// File: rtl/axis_out_skid_buffer.sv
// Two-entry register FIFO for AXIS output beats.
// Entry 0 is always the head; occupancy is exported.
module axis_out_skid_buffer #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         push_last,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic         head_last,
  output logic [1:0]   occ
);

  logic [W-1:0] d1;
  logic         l1;

  always_ff @(posedge clk) begin
    if (rst) begin
      occ       <= '0;
      head_data <= '0;
      head_last <= 1'b0;
      d1        <= '0;
      l1        <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) begin
            head_data <= push_data;
            head_last <= push_last;
          end else begin
            d1 <= push_data;
            l1 <= push_last;
          end
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head_data <= d1;
          head_last <= l1;
          occ       <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd2) begin
            head_data <= d1;
            head_last <= l1;
            d1        <= push_data;
            l1        <= push_last;
          end else begin
            head_data <= push_data;
            head_last <= push_last;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/counter.sv
// Up-counter with synchronous reset and clear.
// Clear has priority over increment.
module counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr)
      q <= '0;
    else if (inc)
      q <= q + 1'b1;
  end

endmodule

// File: rtl/result_bram_datapath.sv
// Inferred simple dual-port BRAM for one result frame.
// Port A writes, port B reads with one cycle of latency.
module result_bram_datapath #(
  parameter int DW = 64,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          wea,
  input  logic [AW-1:0] addra,
  input  logic [DW-1:0] dina,
  input  logic          enb,
  input  logic [AW-1:0] addrb,
  output logic [DW-1:0] doutb
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (wea)
      mem[addra] <= dina;
  end

  always_ff @(posedge clk) begin
    if (enb)
      doutb <= mem[addrb];
  end

endmodule

// File: rtl/result_bram_axis_tx.sv
// Collects one frame of conv2d results into BRAM,
// then streams it out as an AXI4-Stream master.
module result_bram_axis_tx
  import conv2d_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W,
  parameter int ADDR_WIDTH = ADDR_W
) (
  input  logic                    clk,
  input  logic                    Reset,
  input  logic [ADDR_WIDTH:0]     FRAME_SIZE,
  input  logic                    load_start,
  input  logic                    res_wr_valid,
  input  logic [DATA_WIDTH-1:0]   res_wr_data,
  input  logic                    stream_start,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tvalid,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic                    m_axis_tlast,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    last_store,
  output logic                    stream_done,
  output logic                    busy
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH = CW'(2**ADDR_WIDTH);

  tx_state_t state;

  logic [CW-1:0] fs;
  logic [CW-1:0] wr_cnt;
  logic [CW-1:0] rd_cnt;
  logic [CW-1:0] tx_cnt;
  logic          in_flight;
  logic          in_flight_last;
  logic [1:0]    occ;
  logic          start_ok;
  logic          wr_en;
  logic          last_wr;
  logic          stream_go;
  logic          hs;
  logic          fin_beat;
  logic          room;
  logic          rd_en;
  logic          head_last;

  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] head_data;

  assign start_ok  = (state == S_IDLE) && load_start &&
                     (FRAME_SIZE != '0) && (FRAME_SIZE <= DEPTH);
  assign wr_en     = (state == S_LOAD) && res_wr_valid;
  assign last_wr   = wr_en && (wr_cnt == fs - 1'b1);
  assign stream_go = (state == S_LOADED) && stream_start;
  assign hs        = m_axis_tvalid && m_axis_tready;
  assign fin_beat  = hs && (tx_cnt == fs - 1'b1);

  // A beat leaving this cycle frees a slot, keeping 1 beat/cycle.
  assign room  = (({1'b0, occ} + {2'b0, in_flight}) < 3'd2) || hs;
  // First read issues with stream_start so tvalid rises 2 cycles later.
  assign rd_en = ((state == S_STREAM) || stream_go) &&
                 (rd_cnt < fs) && room;

  assign m_axis_tvalid = (occ != 2'd0);
  assign m_axis_tdata  = head_data;
  assign m_axis_tlast  = m_axis_tvalid && head_last;
  assign m_axis_tkeep  = '1;
  assign last_store    = last_wr;
  assign stream_done   = (state == S_DONE);
  assign busy          = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (Reset) begin
      state          <= S_IDLE;
      fs             <= '0;
      in_flight      <= 1'b0;
      in_flight_last <= 1'b0;
    end else begin
      in_flight      <= rd_en;
      in_flight_last <= rd_en && (rd_cnt == fs - 1'b1);
      unique case (state)
        S_IDLE: begin
          if (start_ok) begin
            fs    <= FRAME_SIZE;
            state <= S_LOAD;
          end
        end
        S_LOAD:   if (last_wr)   state <= S_LOADED;
        S_LOADED: if (stream_go) state <= S_STREAM;
        S_STREAM: if (fin_beat)  state <= S_DONE;
        S_DONE:                  state <= S_IDLE;
        default:                 state <= S_IDLE;
      endcase
    end
  end

  counter #(.W(CW)) u_wr_cnt (
    .clk (clk),
    .rst (Reset),
    .clr (last_wr),
    .inc (wr_en),
    .q   (wr_cnt)
  );

  counter #(.W(CW)) u_rd_cnt (
    .clk (clk),
    .rst (Reset),
    .clr (state == S_DONE),
    .inc (rd_en),
    .q   (rd_cnt)
  );

  counter #(.W(CW)) u_tx_cnt (
    .clk (clk),
    .rst (Reset),
    .clr (state == S_DONE),
    .inc (hs),
    .q   (tx_cnt)
  );

  result_bram_datapath #(
    .DW (DATA_WIDTH),
    .AW (ADDR_WIDTH)
  ) u_bram (
    .clk   (clk),
    .wea   (wr_en),
    .addra (wr_cnt[ADDR_WIDTH-1:0]),
    .dina  (res_wr_data),
    .enb   (rd_en),
    .addrb (rd_cnt[ADDR_WIDTH-1:0]),
    .doutb (rd_data)
  );

  axis_out_skid_buffer #(.W(DATA_WIDTH)) u_skid (
    .clk       (clk),
    .rst       (Reset),
    .push      (in_flight),
    .push_data (rd_data),
    .push_last (in_flight_last),
    .pop       (hs),
    .head_data (head_data),
    .head_last (head_last),
    .occ       (occ)
  );

endmodule

// File: tb/tb_result_bram_axis_tx.sv
// Scoreboard bench for result_bram_axis_tx.
// Writes frames, streams them out and compares every beat.
module tb_result_bram_axis_tx;
  import conv2d_pkg::*;

  logic        clk = 0;
  logic        Reset = 1;
  logic [10:0] FRAME_SIZE = '0;
  logic        load_start = 0;
  logic        res_wr_valid = 0;
  logic [63:0] res_wr_data = '0;
  logic        stream_start = 0;
  logic        m_axis_tready = 0;
  logic        m_axis_tvalid;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tlast;
  logic [7:0]  m_axis_tkeep;
  logic        last_store;
  logic        stream_done;
  logic        busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int beats = 0;
  int done_cnt = 0;
  int first_hs = -1;
  int last_hs = -1;
  int rmode = 0;
  int pi = 0;
  logic [5:0] pat = 6'b101001;
  logic [64:0] q[$];

  result_bram_axis_tx dut (
    .clk           (clk),
    .Reset         (Reset),
    .FRAME_SIZE    (FRAME_SIZE),
    .load_start    (load_start),
    .res_wr_valid  (res_wr_valid),
    .res_wr_data   (res_wr_data),
    .stream_start  (stream_start),
    .m_axis_tready (m_axis_tready),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tkeep  (m_axis_tkeep),
    .last_store    (last_store),
    .stream_done   (stream_done),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // tready: 0 = always 1, 1 = 1,0,0,1,0,1 pattern, 2 = held low
  initial forever begin
    @(posedge clk);
    #1;
    case (rmode)
      0: m_axis_tready = 1'b1;
      1: begin
        m_axis_tready = pat[pi % 6];
        pi++;
      end
      default: m_axis_tready = 1'b0;
    endcase
  end

  // output monitor: scoreboard pops, stall stability, done pulse
  initial begin
    logic        stall_prev;
    logic        pend_done;
    logic [63:0] pdata;
    logic        plast;
    logic [64:0] e;
    stall_prev = 0;
    pend_done = 0;
    pdata = '0;
    plast = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (stall_prev) begin
        chk("stall_valid", 64'(m_axis_tvalid), 64'd1);
        chk("stall_data", m_axis_tdata, pdata);
        chk("stall_last", 64'(m_axis_tlast), 64'(plast));
      end
      stall_prev = m_axis_tvalid && !m_axis_tready && !Reset;
      pdata = m_axis_tdata;
      plast = m_axis_tlast;
      if (pend_done) begin
        chk("stream_done", 64'(stream_done), 64'd1);
        done_cnt++;
        pend_done = 0;
      end
      if (m_axis_tvalid && m_axis_tready && !Reset) begin
        if (q.size() == 0) begin
          chk("extra_beat", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          chk("tdata", m_axis_tdata, e[63:0]);
          chk("tlast", 64'(m_axis_tlast), 64'(e[64]));
        end
        beats++;
        if (first_hs < 0) first_hs = cyc;
        if (m_axis_tlast) begin
          last_hs = cyc;
          pend_done = 1;
        end
      end
    end
  end

  task automatic load_frame(input int n, input logic [63:0] base,
                            input bit ss_misuse);
    FRAME_SIZE = 11'(n);
    load_start = 1;
    @(posedge clk);
    #1;
    load_start = 0;
    FRAME_SIZE = 11'd3;
    for (int i = 0; i < n; i++) begin
      res_wr_valid = 1;
      res_wr_data = base + 64'(i);
      stream_start = ss_misuse && (i == 0);
      @(negedge clk);
      chk("last_store", 64'(last_store), 64'(i == n - 1));
      q.push_back({i == n - 1, base + 64'(i)});
      @(posedge clk);
      #1;
    end
    res_wr_valid = 0;
    stream_start = 0;
  endtask

  task automatic stream_frame(input int n, input int rm,
                              input bit ls_misuse);
    int d0;
    int k;
    rmode = rm;
    pi = 0;
    first_hs = -1;
    d0 = done_cnt;
    stream_start = 1;
    @(posedge clk);
    #1;
    stream_start = 0;
    @(negedge clk);
    chk("lat_1", 64'(m_axis_tvalid), 64'd0);
    @(negedge clk);
    chk("lat_2", 64'(m_axis_tvalid), 64'd1);
    if (ls_misuse) begin
      FRAME_SIZE = 11'd3;
      load_start = 1;
      @(posedge clk);
      #1;
      load_start = 0;
    end
    for (k = 0; k < 5000 && done_cnt == d0; k++) @(posedge clk);
    if (done_cnt == d0) chk("done_timeout", 64'd0, 64'd1);
    @(negedge clk);
    chk("busy_after", 64'(busy), 64'd0);
    chk("q_empty", 64'(q.size()), 64'd0);
    if (rm == 0) chk("rate", 64'(last_hs - first_hs), 64'(n - 1));
  endtask

  initial begin
    int b0;
    int k;
    repeat (2) @(posedge clk);
    #1;
    Reset = 0;
    @(negedge clk);
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
    chk("rst_tdata", m_axis_tdata, 64'd0);
    chk("rst_last_store", 64'(last_store), 64'd0);
    chk("rst_done", 64'(stream_done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("tkeep", 64'(m_axis_tkeep), 64'hff);

    // writes in IDLE must be dropped
    @(posedge clk);
    #1;
    res_wr_valid = 1;
    res_wr_data = 64'hdead;
    repeat (3) @(posedge clk);
    #1;
    res_wr_valid = 0;

    FRAME_SIZE = 11'd0;
    load_start = 1;
    @(posedge clk);
    #1;
    load_start = 0;
    @(negedge clk);
    chk("fs0_idle", 64'(busy), 64'd0);
    FRAME_SIZE = 11'd1025;
    load_start = 1;
    @(posedge clk);
    #1;
    load_start = 0;
    @(negedge clk);
    chk("fs_big_idle", 64'(busy), 64'd0);

    @(posedge clk);
    #1;
    load_frame(4, 64'ha5a5_0000_0000_0001, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("loaded_busy", 64'(busy), 64'd1);
    chk("loaded_novalid", 64'(m_axis_tvalid), 64'd0);
    @(posedge clk);
    #1;
    stream_frame(4, 0, 0);

    @(posedge clk);
    #1;
    load_frame(8, 64'h0123_4567_89ab_0010, 0);
    stream_frame(8, 1, 1);

    @(posedge clk);
    #1;
    load_frame(1, 64'hffff_0000_1111_0100, 0);
    stream_frame(1, 0, 0);

    @(posedge clk);
    #1;
    load_frame(1024, 64'h1000_0000_0000_0000, 0);
    stream_frame(1024, 0, 0);

    // abort mid-stream with reset after 3 beats
    @(posedge clk);
    #1;
    load_frame(8, 64'h2000_0000_0000_0000, 0);
    rmode = 0;
    b0 = beats;
    stream_start = 1;
    @(posedge clk);
    #1;
    stream_start = 0;
    for (k = 0; k < 50 && beats - b0 < 3; k++) @(posedge clk);
    rmode = 2;
    repeat (2) @(posedge clk);
    #1;
    Reset = 1;
    @(posedge clk);
    #1;
    Reset = 0;
    @(negedge clk);
    chk("abort_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_beats", 64'(beats - b0), 64'd3);
    q.delete();

    @(posedge clk);
    #1;
    load_frame(2, 64'h3000_0000_0000_00aa, 0);
    stream_frame(2, 0, 0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/result_bram_axis_tx.md
Name: result_BRAM_axis_tx

Overview:
Output-side counterpart of the kernel loader. It collects one frame of conv2d results from the datapath into a simple dual-port BRAM using a write-address counter. It then streams the frame out on an AXI4-Stream master port, using a read-address counter and a 2-entry output buffer, with TLAST on the final beat. It sits between the conv2d accumulator/output stage and the DMA S2MM channel.

Parameters:
DATA_WIDTH, 64, width of one result word / AXIS beat (4 x 16-bit pixels)
ADDR_WIDTH, 10, BRAM address width; depth = 2**ADDR_WIDTH words

Ports:
clk  input  1  system clock, all logic on rising edge
Reset  input  1  synchronous, active-high reset
FRAME_SIZE  input  ADDR_WIDTH+1  beats per frame, 1..2**ADDR_WIDTH; sampled on load_start
load_start  input  1  pulse: begin collecting a frame (accepted only in IDLE)
res_wr_valid  input  1  result word valid from datapath (no backpressure)
res_wr_data  input  DATA_WIDTH  result word
stream_start  input  1  pulse: begin transmitting the stored frame (accepted only in LOADED)
m_axis_tready  input  1  AXIS ready from DMA
m_axis_tvalid  output  1  AXIS valid
m_axis_tdata  output  DATA_WIDTH  AXIS data
m_axis_tlast  output  1  high on the final beat of the frame
m_axis_tkeep  output  DATA_WIDTH/8  constant all-ones
last_store  output  1  1-cycle pulse when the final frame word is written
stream_done  output  1  1-cycle pulse after the final beat handshake
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (synchronous): state=IDLE; both counters=0; buffer empty; in-flight flag=0. tvalid, tlast, last_store, stream_done and busy are all 0. tdata=0.
- States: IDLE -> LOAD on load_start with FRAME_SIZE != 0. FRAME_SIZE=0 or FRAME_SIZE > 2**ADDR_WIDTH: load_start is ignored and the block stays in IDLE.
- LOAD: each res_wr_valid writes res_wr_data at addra=wr_cnt, then wr_cnt++. On the write where wr_cnt==FRAME_SIZE-1, last_store pulses in the same cycle, wr_cnt clears, and the next state is LOADED. res_wr_valid outside LOAD is dropped (no write, no count).
- LOADED: hold until stream_start -> STREAM. stream_start in any other state is ignored. load_start in LOADED is ignored.
- STREAM, read side: BRAM read latency is 1 cycle. A read (enb=1, addrb=rd_cnt, rd_cnt++) is issued when all of the following hold:
  - rd_cnt < FRAME_SIZE;
  - buffer occupancy + in-flight reads < 2.
  Read data lands in the buffer the following cycle.
- STREAM, output side: the buffer head drives tdata and tvalid. tlast=1 when the head word is index FRAME_SIZE-1. Beat index is tracked by tx_cnt, incremented on each tvalid&&tready.
- AXIS rules:
  - tvalid never deasserts, and tdata/tlast never change, while tvalid=1 and tready=0.
  - tvalid does not depend combinationally on tready.
- Latency: first tvalid rises 2 cycles after the stream_start cycle.
- Throughput: 1 beat/cycle sustained while tready is held high.
- Frame end: on the handshake with tlast=1, next cycle is DONE. DONE drives stream_done=1 for one cycle and goes to IDLE; rd_cnt and tx_cnt clear.
- Simultaneous write and read: cannot occur, because LOAD and STREAM are exclusive.
- Reset mid-LOAD or mid-STREAM: everything returns to IDLE at that edge and tvalid=0 next cycle. This is the only sanctioned abort. BRAM contents are not cleared.
- FRAME_SIZE is latched on load_start; changes afterwards have no effect until the next frame.

Decomposition:
- Shared package conv2d_pkg:
  - state encoding typedef (IDLE, LOAD, LOADED, STREAM, DONE);
  - DATA_WIDTH and ADDR_WIDTH defaults.
- Reuse the existing counter module for wr_cnt, rd_cnt and tx_cnt.
- One new sub-module, axis_out_skid_buffer: 2-entry register FIFO holding the data and last bits, with occupancy output.
- The BRAM itself is a separate inferred simple-dual-port module, result_BRAM_datapath, parallel to the kernel datapath.

Test Plan:
- FRAME_SIZE=4, words 0x..01-0x..04, then stream_start with tready=1 -> last_store on the 4th write; tvalid 2 cycles after start; 4 consecutive beats 01..04; tlast only on 04; stream_done one cycle after.
- FRAME_SIZE=8, tready toggling 1,0,0,1,0,1... -> all 8 beats in order, no drop or duplicate; tdata/tlast stable across every stall cycle.
- FRAME_SIZE=1 -> single beat with tvalid&tlast=1; stream_done follows; busy low afterwards.
- FRAME_SIZE=1024 (full depth), tready=1 -> 1024 beats in 1024 consecutive cycles; tlast on beat 1023; addresses wrap cleanly to 0 for the next frame.
- Protocol misuse:
  - stream_start during LOAD: ignored;
  - load_start during STREAM: ignored;
  - res_wr_valid in IDLE: no write, counter stays 0;
  - FRAME_SIZE=0 load_start: stays IDLE.
- Reset asserted mid-STREAM (beat 3 of 8, tready=0) -> next cycle tvalid=0, busy=0; a new 2-beat frame then streams correctly.
